// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter, LSB first, fed by a small circular FIFO.
// Back-to-back frames leave no idle gap between stop and start bits.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          pop;
  logic          push;
  logic          bit_end;
  logic          not_empty;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign in_ready   = (fifo_count != FULL);
  assign not_empty  = (fifo_count != '0);
  assign push       = in_valid && in_ready;
  assign bit_end    = (cnt == LAST);
  assign busy       = (state != IDLE) || not_empty;
  assign frame_done = (state == STOP) && bit_end;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    tx_n    = tx;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (not_empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n    = 1'b0;
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          tx_n    = shift[0];
          idx_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
            idx_n   = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          // chain straight into the next start bit when data is waiting
          if (not_empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx    <= tx_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // storage is not reset; the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-serial UART transmitter with a small input FIFO. Sits directly downstream of the change-detecting send stage: it accepts 8-bit words on a valid/ready handshake and shifts them out on the board TX pin as 8N1 frames, LSB first. Its `in_ready` output drives the upstream stage's ready input, so bytes are never dropped while a frame is in flight.

## Interface

- `CLKS_PER_BIT`, default 10416: clock cycles per UART bit (100 MHz / 9600 baud). Legal range is ≥ 2.
- `FIFO_DEPTH`, default 4: number of entries. Must be a power of two, ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  byte to transmit.
- `in_valid`  in  1  `in_data` is presented.
- `in_ready`  out  1  FIFO not full. A push occurs on any edge where `in_valid && in_ready`.
- `tx`  out  1  serial line, idle high. Registered output.
- `busy`  out  1  a frame is in progress, or the FIFO is non-empty.
- `frame_done`  out  1  one-cycle pulse on the last cycle of each stop bit.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  current occupancy.

## Operation

- Reset values (asserted asynchronously while `rst_n`=0):
  - `tx`=1, `busy`=0, `frame_done`=0, `fifo_count`=0, `in_ready`=1.
  - State is IDLE; the baud counter, bit index and FIFO pointers are 0.
  - FIFO contents are not cleared.
  - Reset mid-frame aborts the frame: `tx` returns high immediately, and queued bytes are discarded.
- FIFO behaviour:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - `in_ready` = (`fifo_count` != FIFO_DEPTH), computed from registered count. There is no pass-through when full: a push is refused on the edge where the FIFO is full, even if a pop happens on that same edge.
  - Push and pop on the same edge leaves `fifo_count` unchanged, and both take effect.
  - Pop never happens when empty. Push never happens when full.
- State machine:
  - IDLE: `tx`=1. When `fifo_count`>0, pop the head into the shift register, load `tx`=0, clear the baud counter, go to START.
  - START: hold for CLKS_PER_BIT cycles, then `tx` ← shift[0], bit index=0, go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles. Then shift right and increment the index. After bit 7 completes, `tx`=1 and go to STOP.
  - STOP: hold for CLKS_PER_BIT cycles. On the final cycle of the stop bit, `frame_done`=1.
    - If the FIFO is non-empty, pop, set `tx`=0, go to START. This gives back-to-back frames with no idle gap.
    - Otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Width is clog2(CLKS_PER_BIT).
  - It is cleared on every state entry from IDLE.
- `busy` = (state != IDLE) || (`fifo_count` != 0).

## Timing

- Start latency: a push accepted at edge N into an empty FIFO in IDLE is popped at edge N+1. `tx` falls after edge N+1.
- Bit period: every bit (start, 8 data, stop) is exactly CLKS_PER_BIT cycles. A frame lasts 10×CLKS_PER_BIT cycles.
- Back-to-back frames: the falling edge of the next start bit occurs on the edge immediately after the last stop-bit cycle, with no extra idle cycle.
- `frame_done` is high during that last stop-bit cycle only, one cycle per frame.
- `in_ready` deasserts on the edge after the push that fills the FIFO. It reasserts on the edge after the first pop from a full FIFO.
- `in_valid` held high with `in_ready` low: no push happens. `in_data` may change freely.

## Test plan

All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.

- **Reset:** hold `rst_n`=0 for 3 cycles, then release → `tx`=1, `busy`=0, `in_ready`=1, `fifo_count`=0, and `tx` stays high for 20 cycles.
- **Single byte:** push 0xA5 once → `tx` falls 1 cycle after the push edge. The line sequence per 4-cycle bit is 0, then 1,0,1,0,0,1,0,1, then 1. `frame_done` pulses once at cycle 40 after the fall. `busy` then drops.
- **Back-to-back:** push 0x00 and 0xFF on consecutive cycles → two frames with no gap. Between the two frames the stop bit is exactly 4 cycles high, followed immediately by the next start bit. `frame_done` pulses twice, 40 cycles apart.
- **FIFO full:** push 0x11..0x16 on 6 consecutive cycles with `in_valid` held high →
  - 0x11 is popped at edge 2.
  - 0x12..0x15 fill the FIFO. `in_ready`=0 after the 5th push, and 0x16 is refused.
  - The line carries 0x11..0x15 in order; 0x16 never appears.
- **Push at full while a pop occurs:** FIFO full, `in_valid`=1 on the stop-bit last cycle → that push is refused. `fifo_count` goes 4→3, and `in_ready` rises the next cycle.
- **Reset mid-frame:** push 0x3C, assert `rst_n`=0 during data bit 3 → `tx`=1 asynchronously, `busy`=0. After release, `tx` stays idle and no partial-frame continuation appears.
